// File: rtl/b_to_g.sv
// Binary to reflected-Gray converter: combinational result plus a registered,
// valid-qualified copy with a bit-change monitor against the last valid sample.
module b_to_g #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]           bin,
  output logic [WIDTH-1:0]           gray,
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           gray_q,
  output logic                       out_valid,
  output logic [$clog2(WIDTH+1)-1:0] diff_bits,
  output logic                       single_step
);

  localparam int CNT_W = $clog2(WIDTH+1);

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  logic             have_prev;
  logic [CNT_W-1:0] diff_p0;

  // Stage p0: conversion and distance from the retained baseline
  assign gray    = bin ^ (bin >> 1);
  assign diff_p0 = popcount(gray ^ gray_q);

  // Stage p1: registered result; idle cycles keep gray_q as the baseline
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q      <= '0;
      out_valid   <= 1'b0;
      diff_bits   <= '0;
      single_step <= 1'b0;
      have_prev   <= 1'b0;
    end else if (in_valid) begin
      gray_q      <= gray;
      out_valid   <= 1'b1;
      diff_bits   <= have_prev ? diff_p0 : '0;
      single_step <= have_prev && (diff_p0 == CNT_W'(1));
      have_prev   <= 1'b1;
    end else begin
      out_valid   <= 1'b0;
      diff_bits   <= '0;
      single_step <= 1'b0;
    end
  end

endmodule

// File: tb/tb_b_to_g.sv
// Randomized and directed bench for b_to_g (WIDTH = 4) against a behavioural
// model tracking the last valid Gray value.
module tb_b_to_g;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] bin = '0;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] gray_q;
  logic             out_valid;
  logic [CNT_W-1:0] diff_bits;
  logic             single_step;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  int exp_q = 0, exp_valid = 0, exp_diff = 0, exp_single = 0;
  int last_gray = 0;
  bit have = 0;

  b_to_g #(.WIDTH(WIDTH)) dut (
    .bin(bin), .gray(gray), .clk(clk), .rst(rst), .in_valid(in_valid),
    .gray_q(gray_q), .out_valid(out_valid), .diff_bits(diff_bits),
    .single_step(single_step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & ((1 << WIDTH) - 1);
  endfunction

  // Behavioural model: outputs follow from the last valid sample
  always @(posedge clk) begin
    int g;
    if (rst) begin
      exp_q = 0; exp_valid = 0; exp_diff = 0; exp_single = 0; have = 0;
    end else if (in_valid) begin
      g = to_gray(int'(bin));
      exp_diff   = have ? $countones(g ^ last_gray) : 0;
      exp_single = (have && exp_diff == 1) ? 1 : 0;
      exp_valid  = 1;
      exp_q      = g;
      last_gray  = g;
      have       = 1;
    end else begin
      exp_valid = 0; exp_diff = 0; exp_single = 0;
    end
  end

  // Compare process, every cycle
  always @(posedge clk) begin
    #1;
    chk("gray_q", gray_q, exp_q);
    chk("out_valid", out_valid, exp_valid);
    chk("diff_bits", diff_bits, exp_diff);
    chk("single_step", single_step, exp_single);
    chk("gray_comb", gray, to_gray(int'(bin)));
  end

  task automatic cyc(input logic r, input logic v, input logic [WIDTH-1:0] b);
    @(negedge clk);
    rst = r; in_valid = v; bin = b;
    @(posedge clk);
    #2;
  endtask

  task automatic comb_check(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; bin = b;
    #1;
    chk("gray_vec", gray, e);
  endtask

  logic [WIDTH-1:0] vb [9] = '{4'b0100, 4'b0001, 4'b1001, 4'b0011, 4'b1101,
                               4'b0101, 4'b0010, 4'b0000, 4'b1111};
  logic [WIDTH-1:0] vg [9] = '{4'b0110, 4'b0001, 4'b1101, 4'b0010, 4'b1011,
                               4'b0111, 4'b0011, 4'b0000, 4'b1000};

  initial begin
    // Reset held with valid input present
    cyc(1'b1, 1'b1, 4'b1010);
    cyc(1'b1, 1'b1, 4'b1010);
    chk("rst_gray_q", gray_q, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_diff", diff_bits, 0);
    chk("rst_single", single_step, 1'b0);
    chk("rst_gray_comb", gray, 4'b1111);

    // Literal combinational vectors and exhaustive sweep
    for (int i = 0; i < 9; i++) comb_check(vb[i], vg[i]);
    for (int i = 0; i < 16; i++) comb_check(4'(i), 4'(i ^ (i >> 1)));

    // Reset again to get a clean first sample, then latency check
    cyc(1'b1, 1'b0, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0011);
    chk("first_gray_q", gray_q, 4'b0010);
    chk("first_valid", out_valid, 1'b1);
    chk("first_diff", diff_bits, 0);
    chk("first_single", single_step, 1'b0);

    // Incrementing count with wrap
    for (int i = 0; i <= 16; i++) begin
      cyc(1'b0, 1'b1, 4'(i % 16));
      if (i >= 1) begin
        chk("inc_diff", diff_bits, 1);
        chk("inc_single", single_step, 1'b1);
      end
    end
    chk("wrap_gray_q", gray_q, 4'b0000);

    // Non-adjacent jump, idle gap, retained baseline
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0101);
    chk("jump_gray_q", gray_q, 4'b0111);
    chk("jump_diff", diff_bits, 3);
    chk("jump_single", single_step, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 4'(i + 9));
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_hold", gray_q, 4'b0111);
    end
    cyc(1'b0, 1'b1, 4'b0100);
    chk("gap_gray_q", gray_q, 4'b0110);
    chk("gap_diff", diff_bits, 1);
    chk("gap_single", single_step, 1'b1);

    // Repeat, then mid-stream reset
    cyc(1'b0, 1'b1, 4'b0110);
    chk("rep1_diff", diff_bits, 2);
    cyc(1'b0, 1'b1, 4'b0110);
    chk("rep2_diff", diff_bits, 0);
    chk("rep2_single", single_step, 1'b0);
    cyc(1'b1, 1'b1, 4'b0001);
    chk("mid_rst_valid", out_valid, 1'b0);
    cyc(1'b0, 1'b1, 4'b0111);
    chk("post_rst_gray_q", gray_q, 4'b0100);
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_diff", diff_bits, 0);
    chk("post_rst_single", single_step, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
          4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
